parking_lot_ctrl: RTL and testbench

//  Sequences the two-digit BCD occupancy counter of the parking lot. Watches two

---
 rtl/parking_lot_ctrl.sv | 173 +++++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// Gate sequencer for the parking-lot occupancy counter. It watches the outer (A) and inner (B)
// photo-sensors, recognises complete entries and exits, and drives inc/dec pulses plus status flags.
module parking_lot_ctrl #(
   parameter int         DEBOUNCE = 16,
   parameter int         TIMEOUT  = 1000000,
   parameter logic [7:0] CAPACITY = 8'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sensor_a,
   input  logic       sensor_b,
   input  logic [7:0] count,
   output logic       inc,
   output logic       dec,
   output logic       full,
   output logic       empty,
   output logic       reject,
   output logic       err,
   output logic       busy
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

   logic [1:0] raw;
   logic [1:0] filt;   // {fa, fb}

   assign raw = {sensor_a, sensor_b};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sensor
         logic          sync1_reg;
         logic          sync2_reg;
         logic          filt_reg;
         logic [DW-1:0] db_cnt_reg;

         // The filtered level flips only after DEBOUNCE consecutive samples at the new level.
         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg  <= 1'b0;
               sync2_reg  <= 1'b0;
               filt_reg   <= 1'b0;
               db_cnt_reg <= '0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == filt_reg) begin
                  db_cnt_reg <= '0;
               end else if (db_cnt_reg == DB_LAST) begin
                  filt_reg   <= sync2_reg;
                  db_cnt_reg <= '0;
               end else begin
                  db_cnt_reg <= db_cnt_reg + 1'b1;
               end
            end
         end

         assign filt[gi] = filt_reg;
      end
   endgenerate

   state_t        state_reg;
   state_t        state_next;
   logic [TW-1:0] timer_reg;
   logic          commit_in;
   logic          commit_out;
   logic          seq_err;

   always_comb begin
      state_next = state_reg;
      commit_in  = 1'b0;
      commit_out = 1'b0;
      seq_err    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (filt == 2'b10)      state_next = EN1;
            else if (filt == 2'b01) state_next = EX1;
         end
         EN1: begin
            case (filt)
               2'b11:   state_next = EN2;
               2'b00:   state_next = IDLE;
               2'b01:   begin state_next = IDLE; seq_err = 1'b1; end
               default: state_next = EN1;
            endcase
         end
         EN2: begin
            case (filt)
               2'b01:   state_next = EN3;
               2'b10:   state_next = EN1;
               2'b00:   begin state_next = IDLE; seq_err = 1'b1; end
               default: state_next = EN2;
            endcase
         end
         EN3: begin
            case (filt)
               2'b00:   begin state_next = IDLE; commit_in = 1'b1; end
               2'b11:   state_next = EN2;
               2'b10:   begin state_next = IDLE; seq_err = 1'b1; end
               default: state_next = EN3;
            endcase
         end
         EX1: begin
            case (filt)
               2'b11:   state_next = EX2;
               2'b00:   state_next = IDLE;
               2'b10:   begin state_next = IDLE; seq_err = 1'b1; end
               default: state_next = EX1;
            endcase
         end
         EX2: begin
            case (filt)
               2'b10:   state_next = EX3;
               2'b01:   state_next = EX1;
               2'b00:   begin state_next = IDLE; seq_err = 1'b1; end
               default: state_next = EX2;
            endcase
         end
         EX3: begin
            case (filt)
               2'b00:   begin state_next = IDLE; commit_out = 1'b1; end
               2'b11:   state_next = EX2;
               2'b01:   begin state_next = IDLE; seq_err = 1'b1; end
               default: state_next = EX3;
            endcase
         end
         default: state_next = IDLE;
      endcase
   end

   // Commit decisions use the registered flags, which already track count with one cycle of lag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         inc       <= 1'b0;
         dec       <= 1'b0;
         reject    <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         full      <= 1'b0;
         empty     <= 1'b1;
      end else begin
         full   <= (count >= CAPACITY);
         empty  <= (count == 8'h00);
         inc    <= 1'b0;
         dec    <= 1'b0;
         reject <= 1'b0;
         err    <= 1'b0;
         if (state_reg != IDLE && timer_reg == TO_LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            timer_reg <= '0;
            err       <= 1'b1;
         end else begin
            state_reg <= state_next;
            busy      <= (state_next != IDLE);
            if (state_next != state_reg || state_reg == IDLE) timer_reg <= '0;
            else                                              timer_reg <= timer_reg + 1'b1;
            inc    <= commit_in & ~full;
            reject <= commit_in & full;
            dec    <= commit_out & ~empty;
            err    <= seq_err | (commit_out & empty);
         end
      end
   end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Randomised bench for parking_lot_ctrl with an attached BCD occupancy counter and a
// sequence-level model of entries and exits.
module tb_parking_lot_ctrl;

   localparam int         DEBOUNCE = 4;
   localparam int         TIMEOUT  = 64;
   localparam logic [7:0] CAPACITY = 8'h03;
   localparam int         CAP_INT  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       sensor_a;
   logic       sensor_b;
   logic [7:0] count;
   logic       inc, dec, full, empty, reject, err, busy;

   parking_lot_ctrl #(
      .DEBOUNCE(DEBOUNCE),
      .TIMEOUT (TIMEOUT),
      .CAPACITY(CAPACITY)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sensor_a(sensor_a),
      .sensor_b(sensor_b),
      .count   (count),
      .inc     (inc),
      .dec     (dec),
      .full    (full),
      .empty   (empty),
      .reject  (reject),
      .err     (err),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Occupancy counter fed by the DUT pulses, presented as two BCD digits.
   int occ_hw;
   always @(posedge clk) begin
      if (reset)                   occ_hw <= 0;
      else if (inc && occ_hw < 99) occ_hw <= occ_hw + 1;
      else if (dec && occ_hw > 0)  occ_hw <= occ_hw - 1;
   end
   assign count = {4'(occ_hw / 10), 4'(occ_hw % 10)};

   int n_inc = 0, n_dec = 0, n_err = 0, n_rej = 0, n_both = 0;
   always @(posedge clk) begin
      if (!reset) begin
         if (inc)        n_inc  <= n_inc + 1;
         if (dec)        n_dec  <= n_dec + 1;
         if (err)        n_err  <= n_err + 1;
         if (reject)     n_rej  <= n_rej + 1;
         if (inc && dec) n_both <= n_both + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Model: a passage is the level walk 00,10,11,01,00 in (lead,trail) order, where the lead sensor
   // is A for an entry and B for an exit. One step forward advances, one step back retreats
   // (retreating off the first step abandons quietly), anything else is an error.
   int pat[5] = '{0, 2, 3, 1, 0};
   int m_dir  = 0;   // 0 idle, 1 entering, -1 leaving
   int m_pos  = 0;
   int m_occ  = 0;
   int e_inc  = 0, e_dec = 0, e_err = 0, e_rej = 0;

   task automatic model_apply(input logic [1:0] lv);
      int  lt;
      bit  again;
      again = 1'b1;
      while (again) begin
         again = 1'b0;
         if (m_dir == 0) begin
            if (lv == 2'b10)      begin m_dir = 1;  m_pos = 1; end
            else if (lv == 2'b01) begin m_dir = -1; m_pos = 1; end
         end else begin
            lt = (m_dir == 1) ? int'(lv) : int'({lv[0], lv[1]});
            if (lt == pat[m_pos]) begin
               // holding the same level
            end else if (lt == pat[m_pos + 1]) begin
               if (m_pos == 3) begin
                  if (m_dir == 1) begin
                     if (m_occ >= CAP_INT) e_rej++;
                     else begin e_inc++; m_occ++; end
                  end else begin
                     if (m_occ == 0) e_err++;
                     else begin e_dec++; m_occ--; end
                  end
                  m_dir = 0;
               end else begin
                  m_pos++;
               end
            end else if (lt == pat[m_pos - 1]) begin
               if (m_pos == 1) m_dir = 0;
               else            m_pos--;
            end else begin
               e_err++;
               m_dir = 0;
               again = 1'b1;   // the controller re-examines the same level from idle
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".inc"},    n_inc, e_inc);
      check_val({tag, ".dec"},    n_dec, e_dec);
      check_val({tag, ".err"},    n_err, e_err);
      check_val({tag, ".reject"}, n_rej, e_rej);
      check_val({tag, ".busy"},   int'(busy),  int'(m_dir != 0));
      check_val({tag, ".count"},  int'(count), (m_occ / 10) * 16 + (m_occ % 10));
      check_val({tag, ".full"},   int'(full),  int'(m_occ >= CAP_INT));
      check_val({tag, ".empty"},  int'(empty), int'(m_occ == 0));
   endtask

   logic [1:0] cur_lv = 2'b00;

   task automatic step(input string tag, input logic [1:0] lv, input int hold);
      sensor_a = lv[1];
      sensor_b = lv[0];
      cur_lv   = lv;
      repeat (hold) @(negedge clk);
      model_apply(lv);
      check_all(tag);
   endtask

   task automatic entry(input string tag);
      step(tag, 2'b10, 12);
      step(tag, 2'b11, 12);
      step(tag, 2'b01, 12);
      step(tag, 2'b00, 12);
      $display("entry %s: occupancy now %0d (inc=%0d reject=%0d)", tag, m_occ, n_inc, n_rej);
   endtask

   task automatic leave(input string tag);
      step(tag, 2'b01, 12);
      step(tag, 2'b11, 12);
      step(tag, 2'b10, 12);
      step(tag, 2'b00, 12);
      $display("exit %s: occupancy now %0d (dec=%0d err=%0d)", tag, m_occ, n_dec, n_err);
   endtask

   initial begin
      logic [1:0] lv;
      reset    = 1'b1;
      sensor_a = 1'b0;
      sensor_b = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst.inc",    int'(inc),    0);
      check_val("rst.dec",    int'(dec),    0);
      check_val("rst.reject", int'(reject), 0);
      check_val("rst.err",    int'(err),    0);
      check_val("rst.busy",   int'(busy),   0);
      check_val("rst.full",   int'(full),   0);
      check_val("rst.empty",  int'(empty),  1);
      $display("reset: outputs checked");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      entry("entry1");
      leave("exit1");
      leave("exit_empty");
      entry("fill1");
      entry("fill2");
      entry("fill3");
      entry("over");

      // A 3-cycle blip never survives the debouncer.
      sensor_a = 1'b1;
      repeat (3) @(negedge clk);
      sensor_a = 1'b0;
      repeat (15) @(negedge clk);
      check_all("glitch");
      $display("glitch: busy=%0b", busy);

      step("backout", 2'b10, 12);
      step("backout", 2'b00, 12);
      $display("backout: busy=%0b err=%0d", busy, n_err);

      step("illegal", 2'b10, 12);
      step("illegal", 2'b01, 12);
      step("illegal", 2'b00, 12);
      $display("illegal: err=%0d", n_err);

      // Holding A alone outlasts the timeout once; the re-entered sequence then backs out.
      sensor_a = 1'b1;
      repeat (70) @(negedge clk);
      sensor_a = 1'b0;
      repeat (30) @(negedge clk);
      e_err++;
      check_all("timeout");
      $display("timeout: err=%0d busy=%0b", n_err, busy);

      step("rst_mid", 2'b10, 12);
      step("rst_mid", 2'b11, 12);
      reset    = 1'b1;
      sensor_a = 1'b0;
      sensor_b = 1'b0;
      cur_lv   = 2'b00;
      @(negedge clk);
      check_val("rst_mid.inc",   int'(inc),   0);
      check_val("rst_mid.busy",  int'(busy),  0);
      check_val("rst_mid.err",   int'(err),   0);
      check_val("rst_mid.full",  int'(full),  0);
      check_val("rst_mid.empty", int'(empty), 1);
      reset = 1'b0;
      m_dir = 0;
      m_occ = 0;
      repeat (15) @(negedge clk);
      check_all("rst_mid");
      $display("reset mid-sequence: inc=%0d busy=%0b", n_inc, busy);

      for (int i = 0; i < 60; i++) begin
         lv = 2'($urandom_range(0, 3));
         while (lv == cur_lv) lv = 2'($urandom_range(0, 3));
         step("rand", lv, int'($urandom_range(12, 30)));
         $display("rand %0d: level=%b occ=%0d inc=%0d dec=%0d err=%0d rej=%0d",
                  i, lv, m_occ, n_inc, n_dec, n_err, n_rej);
      end
      if (cur_lv != 2'b00) step("rand_end", 2'b00, 20);

      check_val("inc_dec_overlap", n_both, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
